// File: rtl/arb_rr_ctrl.sv
// Round-robin arbiter moving words from four source FIFOs to four class-selected destination FIFOs.
// Optional per-destination push counters are enabled with macro ARB_PUSH_CNT_EN.
module arb_rr_ctrl #(
  parameter int FIFO_UNITS = 4,
  parameter int WORD_SIZE  = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FIFO_UNITS-1:0] fifo_empty,
  input  logic [WORD_SIZE-1:0]  fifo_data_in0,
  input  logic [WORD_SIZE-1:0]  fifo_data_in1,
  input  logic [WORD_SIZE-1:0]  fifo_data_in2,
  input  logic [WORD_SIZE-1:0]  fifo_data_in3,
  input  logic [FIFO_UNITS-1:0] dest_almost_full,
  output logic [FIFO_UNITS-1:0] arb_pop,
  output logic [FIFO_UNITS-1:0] arb_push,
  output logic [WORD_SIZE-1:0]  arb_data_out,
  output logic [1:0]            arb_state
`ifdef ARB_PUSH_CNT_EN
  ,
  output logic [7:0]            push_cnt0,
  output logic [7:0]            push_cnt1,
  output logic [7:0]            push_cnt2,
  output logic [7:0]            push_cnt3
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SERVE = 2'b01,
    STALL = 2'b10
  } state_t;

  state_t                  state, state_next;
  logic [WORD_SIZE-1:0]    words [FIFO_UNITS];
  logic [FIFO_UNITS-1:0]   eligible;
  logic [1:0]              last_grant;
  logic [1:0]              grant_idx;
  logic [1:0]              search_idx;
  logic                    grant_any;
  logic [WORD_SIZE-1:0]    pop_word;
  logic [1:0]              pop_class;
  logic [FIFO_UNITS-1:0]   push_q;

  assign words[0] = fifo_data_in0;
  assign words[1] = fifo_data_in1;
  assign words[2] = fifo_data_in2;
  assign words[3] = fifo_data_in3;

  for (genvar i = 0; i < FIFO_UNITS; i++) begin : g_elig
    assign eligible[i] = !fifo_empty[i] && !dest_almost_full[words[i][WORD_SIZE-1 -: 2]];
  end

  // Search order starts one past the previous winner; the first hit wins.
  always_comb begin
    grant_any  = 1'b0;
    grant_idx  = last_grant;
    search_idx = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      search_idx = last_grant + 2'(k);
      if (!grant_any && eligible[search_idx]) begin
        grant_any = 1'b1;
        grant_idx = search_idx;
      end
    end
  end

  assign pop_word  = words[grant_idx];
  assign pop_class = pop_word[WORD_SIZE-1 -: 2];
  assign arb_pop   = (grant_any && !reset) ? (FIFO_UNITS'(1) << grant_idx) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant   <= 2'd3;
      push_q       <= '0;
      arb_data_out <= '0;
    end else if (grant_any) begin
      last_grant   <= grant_idx;
      push_q       <= FIFO_UNITS'(1) << pop_class;
      arb_data_out <= pop_word;
    end else begin
      push_q       <= '0;
    end
  end

  // A push already registered when reset arrives is suppressed, not delivered.
  assign arb_push = reset ? '0 : push_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    if (!(&fifo_empty)) begin
      state_next = grant_any ? SERVE : STALL;
    end
  end

  assign arb_state = state;

`ifdef ARB_PUSH_CNT_EN
  logic [7:0] cnt [FIFO_UNITS];

  for (genvar d = 0; d < FIFO_UNITS; d++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (reset)          cnt[d] <= '0;
      else if (push_q[d]) cnt[d] <= cnt[d] + 8'd1;
    end
  end

  assign push_cnt0 = cnt[0];
  assign push_cnt1 = cnt[1];
  assign push_cnt2 = cnt[2];
  assign push_cnt3 = cnt[3];
`endif

endmodule

// File: tb/tb_arb_rr_ctrl.sv
// Scoreboard bench for arb_rr_ctrl: queue-based source model, expected pushes queued at pop time.
module tb_arb_rr_ctrl;
  localparam int W = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   fifo_empty = '1;
  logic [3:0]   dest_almost_full = '0;
  logic [W-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic [3:0]   arb_pop, arb_push;
  logic [W-1:0] arb_data_out;
  logic [1:0]   arb_state;
`ifdef ARB_PUSH_CNT_EN
  logic [7:0]   push_cnt0, push_cnt1, push_cnt2, push_cnt3;
`endif

  arb_rr_ctrl #(.FIFO_UNITS(4), .WORD_SIZE(W)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty),
    .fifo_data_in0(d0), .fifo_data_in1(d1), .fifo_data_in2(d2), .fifo_data_in3(d3),
    .dest_almost_full(dest_almost_full), .arb_pop(arb_pop), .arb_push(arb_push),
    .arb_data_out(arb_data_out), .arb_state(arb_state)
`ifdef ARB_PUSH_CNT_EN
    , .push_cnt0(push_cnt0), .push_cnt1(push_cnt1), .push_cnt2(push_cnt2), .push_cnt3(push_cnt3)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int           stamp;
    logic [3:0]   push;
    logic [W-1:0] data;
  } exp_t;

  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  exp_t         sb[$];
  exp_t         e;
  logic [W-1:0] srcq[4][$];
  logic [W-1:0] hd[4];
  int           glog[$];
  logic         rst_v = 1'b1;
  logic [3:0]   af_v = '0;
  int           lg = 3;
  int           exp_state = 0;
  bit           st_valid = 1'b0;
  int           cnt_m[4] = '{default: 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int cls(logic [W-1:0] w);
    return int'(w[W-1:W-2]);
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < 4; i++) if (srcq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [W-1:0] mkword(int c);
    logic [1:0] c2;
    logic [7:0] lo;
    c2 = 2'(c);
    lo = 8'($urandom);
    return {c2, lo};
  endfunction

  task automatic drive();
    reset = rst_v;
    dest_almost_full = af_v;
    for (int i = 0; i < 4; i++) begin
      fifo_empty[i] = (srcq[i].size() == 0);
      hd[i] = fifo_empty[i] ? '0 : srcq[i][0];
    end
    d0 = hd[0]; d1 = hd[1]; d2 = hd[2]; d3 = hd[3];
  endtask

  // Reference: first non-empty source, whose head's destination is not almost full,
  // scanning upward from the previous winner.
  task automatic model();
    logic [3:0]   exp_pop;
    logic [W-1:0] w;
    int           g;
    exp_pop = '0;
    g = -1;
    if (!rst_v) begin
      for (int k = 1; k <= 4; k++) begin
        int i;
        i = (lg + k) % 4;
        if (g < 0 && srcq[i].size() > 0 && !af_v[cls(srcq[i][0])]) g = i;
      end
    end
    if (g >= 0) exp_pop[g] = 1'b1;
    check("pop", arb_pop, exp_pop);
    if (st_valid) check("state", arb_state, exp_state);
    exp_state = rst_v ? 0 : (all_empty() ? 0 : (g >= 0 ? 1 : 2));
    st_valid = 1'b1;
    if (rst_v) begin
      lg = 3;
      sb.delete();
      cnt_m = '{default: 0};
    end else if (g >= 0) begin
      w = srcq[g].pop_front();
      sb.push_back('{stamp: cyc, push: 4'b0001 << cls(w), data: w});
      lg = g;
      cnt_m[cls(w)] = (cnt_m[cls(w)] + 1) % 256;
      glog.push_back(g);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    model();
  endtask

  task automatic drain();
    af_v = '0;
    for (int n = 0; n < 2000; n++) begin
      if (all_empty()) break;
      step();
    end
    step();
    step();
    check("drain_timeout", all_empty() ? 0 : 1, 0);
  endtask

  // Monitor: every visible push must match the oldest outstanding pop, one cycle later.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      check("push_in_reset", arb_push, 4'b0000);
    end else if (arb_push != 4'b0000) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_push: got %0h expected none (cycle %0d)", arb_push, cyc);
      end else begin
        e = sb.pop_front();
        check("push_latency", cyc - e.stamp, 1);
        check("push_onehot", arb_push, e.push);
        check("data_out", arb_data_out, e.data);
      end
    end else if (sb.size() > 0 && sb[0].stamp < cyc) begin
      tests++;
      fails++;
      $display("FAIL missing_push: got 0 expected %0h (cycle %0d)", sb[0].push, cyc);
      void'(sb.pop_front());
    end
  end

  initial begin
    // Reset, then idle with everything empty
    rst_v = 1'b1;
    repeat (3) step();
    rst_v = 1'b0;
    step();
    check("rst_push", arb_push, 4'b0000);
    check("rst_data", arb_data_out, '0);
    check("rst_state", arb_state, 2'b00);
    step();

    // One word per source, class equal to source index
    glog.delete();
    for (int i = 0; i < 4; i++) srcq[i].push_back(mkword(i));
    repeat (6) step();
    check("rr_count", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++) check("rr_order", glog[i], i);

    // Sources 0 and 2 always busy, same destination
    glog.delete();
    for (int n = 0; n < 8; n++) begin
      while (srcq[0].size() < 2) srcq[0].push_back(mkword(1));
      while (srcq[2].size() < 2) srcq[2].push_back(mkword(1));
      step();
    end
    check("alt_count", glog.size(), 8);
    for (int i = 0; i < 8 && i < glog.size(); i++) check("alt_order", glog[i], (i % 2) * 2);
    drain();

    // Destination 2 almost full blocks source 1
    srcq[1].push_back(10'h2A5);
    af_v = 4'b0100;
    step();
    step();
    check("stall_pop", arb_pop, 4'b0000);
    check("stall_state", arb_state, 2'b10);
    af_v = 4'b0000;
    glog.delete();
    step();
    check("unstall_grant", glog.size() == 1 ? glog[0] : -1, 1);
    step();
    check("unstall_push", arb_push, 4'b0100);
    check("unstall_data", arb_data_out, 10'h2A5);
    step();

    // Reset right after a pop drops the in-flight word
    srcq[0].push_back(mkword(3));
    step();
    rst_v = 1'b1;
    step();
    check("rst_kill_push", arb_push, 4'b0000);
    rst_v = 1'b0;
    glog.delete();
    for (int i = 0; i < 4; i++) srcq[i].push_back(mkword($urandom_range(0, 3)));
    step();
    check("post_rst_state", arb_state, 2'b00);
    check("post_rst_grant", glog.size() > 0 ? glog[0] : -1, 0);
    drain();

    // Randomized traffic with sporadic almost-full and reset
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 2) == 0 && srcq[i].size() < 8) srcq[i].push_back(mkword($urandom_range(0, 3)));
      for (int b = 0; b < 4; b++) af_v[b] = ($urandom_range(0, 3) == 0);
      rst_v = ($urandom_range(0, 299) == 0);
      step();
    end
    rst_v = 1'b0;
    drain();

`ifdef ARB_PUSH_CNT_EN
    rst_v = 1'b1;
    step();
    rst_v = 1'b0;
    for (int n = 0; n < 257; n++) srcq[3].push_back(mkword(3));
    drain();
    check("cnt3", push_cnt3, 8'd1);
    check("cnt3_model", push_cnt3, 8'(cnt_m[3]));
    check("cnt0", push_cnt0, 8'd0);
    check("cnt1", push_cnt1, 8'd0);
    check("cnt2", push_cnt2, 8'd0);
`endif

    step();
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
